// File: rtl/bram_snap_capture_if.sv
// Purpose: groups the capture-control, status and read-port signals of bram_snap_capture.
// Latency: n/a (wires only).
// Backpressure: none; the capture stream and the read port carry no ready signal.
//
// Ports (master = stimulus side, slave = capture buffer):
//   arm/circ/len       capture control, circ and len sampled on arm
//   din/din_valid/trig capture data stream and trigger
//   busy/done/trig_addr/wrapped/count  capture status
//   rd_en/rd_addr/rd_data/rd_valid     random-access read port
interface bram_snap_capture_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10
);
    logic                  arm;
    logic                  circ;
    logic [ADDR_WIDTH:0]   len;
    logic [DATA_WIDTH-1:0] din;
    logic                  din_valid;
    logic                  trig;

    logic                  busy;
    logic                  done;
    logic [ADDR_WIDTH-1:0] trig_addr;
    logic                  wrapped;
    logic [ADDR_WIDTH:0]   count;

    logic                  rd_en;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  rd_valid;

    modport master (
        output arm, circ, len, din, din_valid, trig, rd_en, rd_addr,
        input  busy, done, trig_addr, wrapped, count, rd_data, rd_valid
    );

    modport slave (
        input  arm, circ, len, din, din_valid, trig, rd_en, rd_addr,
        output busy, done, trig_addr, wrapped, count, rd_data, rd_valid
    );
endinterface

// File: rtl/bram_snap_capture.sv
// Purpose: arm/trigger capture buffer writing a data stream into block RAM (one-shot or circular pre-trigger).
// Latency: a valid word is written on the edge ending its cycle; reads return RD_LATENCY (1 or 2) cycles after rd_en.
// Backpressure: none; every din_valid word is accepted, and one read per cycle is always accepted.
//
// Ports:
//   clk  single clock for FSM, RAM and read pipeline
//   rst  asynchronous active-high reset (RAM contents are kept)
//   bus  bram_snap_capture_if slave: capture control/status and the read port
module bram_snap_capture #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10,
    parameter int RD_LATENCY = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    bram_snap_capture_if.slave   bus
);
    localparam int DEPTH = 1 << ADDR_WIDTH;

    // Depth expressed in the width of len/count, so len_eff and count compare directly.
    localparam logic [ADDR_WIDTH:0]   DEPTH_W = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0]   CNT_ONE = (ADDR_WIDTH+1)'(1);
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] PTR_MAX = '1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ARMED,
        ST_CAPTURE,
        ST_DONE
    } state_t;

    state_t                state;
    logic                  busy_q;
    logic                  done_q;
    logic                  circ_q;
    logic [ADDR_WIDTH:0]   len_q;
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH:0]   count_q;
    logic [ADDR_WIDTH-1:0] trig_addr_q;
    logic                  wrapped_q;

    logic [ADDR_WIDTH:0]   len_eff;
    logic                  wr_en;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic                  s1_vld;
    logic [DATA_WIDTH-1:0] s1_dat;

    // Zero and anything larger than the RAM both mean "fill the whole RAM".
    assign len_eff = (bus.len == '0 || bus.len > DEPTH_W) ? DEPTH_W : bus.len;

    // Write qualifier. arm has priority over everything, so an arm cycle never writes.
    // In one-shot ARMED only the trigger word is written; in circular ARMED every valid word is.
    always_comb begin
        wr_en = 1'b0;
        if (!bus.arm && bus.din_valid) begin
            case (state)
                ST_ARMED:   wr_en = circ_q | bus.trig;
                ST_CAPTURE: wr_en = 1'b1;
                default:    wr_en = 1'b0;
            endcase
        end
    end

    // Capture FSM with registered status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            circ_q      <= 1'b0;
            len_q       <= '0;
            wr_ptr      <= '0;
            count_q     <= '0;
            trig_addr_q <= '0;
            wrapped_q   <= 1'b0;
        end else if (bus.arm) begin
            // Restart from any state, including mid-capture; RAM is left untouched.
            state       <= ST_ARMED;
            busy_q      <= 1'b1;
            done_q      <= 1'b0;
            circ_q      <= bus.circ;
            len_q       <= len_eff;
            wr_ptr      <= '0;
            count_q     <= '0;
            trig_addr_q <= '0;
            wrapped_q   <= 1'b0;
        end else begin
            // The pointer is only ever 0 when a one-shot trigger word is written,
            // so the same advance rule serves both modes.
            if (wr_en) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end

            case (state)
                ST_ARMED: begin
                    if (wr_en) begin
                        if (circ_q && wr_ptr == PTR_MAX) begin
                            wrapped_q <= 1'b1;
                        end
                        if (bus.trig) begin
                            trig_addr_q <= wr_ptr;
                            count_q     <= CNT_ONE;
                            if (len_q == CNT_ONE) begin
                                state  <= ST_DONE;
                                busy_q <= 1'b0;
                                done_q <= 1'b1;
                            end else begin
                                state  <= ST_CAPTURE;
                            end
                        end
                    end
                end

                ST_CAPTURE: begin
                    if (wr_en) begin
                        count_q <= count_q + CNT_ONE;
                        // The word completing the post-trigger window is still written this cycle.
                        if (count_q + CNT_ONE == len_q) begin
                            state  <= ST_DONE;
                            busy_q <= 1'b0;
                            done_q <= 1'b1;
                        end
                    end
                end

                default: begin
                    // IDLE and DONE wait for arm; outputs hold.
                end
            endcase
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.trig_addr = trig_addr_q;
    assign bus.wrapped   = wrapped_q;
    assign bus.count     = count_q;

    // RAM write port. No reset: captured data survives rst.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= bus.din;
        end
    end

    // RAM read register. Sampling mem on the same edge as the write gives read-first
    // behaviour on an address collision. s1_dat only loads on a request, so the
    // output holds between reads.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_vld <= 1'b0;
            s1_dat <= '0;
        end else begin
            s1_vld <= bus.rd_en;
            if (bus.rd_en) begin
                s1_dat <= mem[bus.rd_addr];
            end
        end
    end

    // Any RD_LATENCY other than 1 builds the two-cycle (output-registered) pipe.
    generate
        if (RD_LATENCY == 1) begin : g_lat1
            assign bus.rd_data  = s1_dat;
            assign bus.rd_valid = s1_vld;
        end else begin : g_lat2
            logic                  s2_vld;
            logic [DATA_WIDTH-1:0] s2_dat;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    s2_vld <= 1'b0;
                    s2_dat <= '0;
                end else begin
                    s2_vld <= s1_vld;
                    if (s1_vld) begin
                        s2_dat <= s1_dat;
                    end
                end
            end

            assign bus.rd_data  = s2_dat;
            assign bus.rd_valid = s2_vld;
        end
    endgenerate
endmodule

// File: tb/tb_bram_snap_capture.sv
// Purpose: self-checking bench for bram_snap_capture against a list-based capture model.
// Latency: checks write-to-done timing and the RD_LATENCY=2 read pipe.
// Backpressure: none exercised; the DUT has no ready signals.
module tb_bram_snap_capture;
    localparam int DW    = 32;
    localparam int AW    = 4;
    localparam int DEPTH = 1 << AW;
    localparam int RL    = 2;
    localparam int MAXN  = 64;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    bram_snap_capture_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    bram_snap_capture #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RD_LATENCY(RL)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int vectors = 0;
    int miss    = 0;

    // Stimulus for one capture: index 0 is the arm cycle, 1..n follow it.
    logic          s_dv   [MAXN];
    logic          s_trig [MAXN];
    logic [DW-1:0] s_din  [MAXN];

    // Expected RAM contents accumulated across captures.
    logic [DW-1:0] exp_mem   [DEPTH];
    bit            exp_known [DEPTH];

    // Model results and observations of the last capture.
    int         m_count, m_trig_addr, m_done_idx, first_done;
    bit         m_done, m_wrapped;
    logic       busy_after_arm, done_after_arm;
    logic [AW:0] count_after_arm;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_stream();
        for (int i = 0; i < MAXN; i++) begin
            s_dv[i]   = 1'b0;
            s_trig[i] = 1'b0;
            s_din[i]  = '0;
        end
    endtask

    // Drives arm at cycle 0 then the stream; circ/len are scrambled after arm
    // because they must only matter when sampled on arm.
    task automatic drive_stream(input logic c, input logic [AW:0] l, input int n);
        first_done = -1;
        for (int i = 0; i <= n; i++) begin
            bus.arm       = (i == 0);
            bus.circ      = (i == 0) ? c : ~c;
            bus.len       = (i == 0) ? l : (AW+1)'($urandom);
            bus.din_valid = s_dv[i];
            bus.trig      = s_trig[i];
            bus.din       = s_din[i];
            tick();
            if (i == 0) begin
                busy_after_arm  = bus.busy;
                done_after_arm  = bus.done;
                count_after_arm = bus.count;
            end
            if (bus.done === 1'b1 && first_done < 0) first_done = i;
        end
        bus.arm       = 1'b0;
        bus.din_valid = 1'b0;
        bus.trig      = 1'b0;
    endtask

    // Reference: list the valid words after arm, locate the first one carrying a trigger,
    // and place words by arithmetic on their position in that list.
    task automatic model_capture(input logic c, input int l, input int n);
        int vidx[$];
        int leff, k, last, pre;
        leff = (l == 0 || l > DEPTH) ? DEPTH : l;
        for (int i = 1; i <= n; i++) if (s_dv[i]) vidx.push_back(i);
        k = -1;
        for (int j = 0; j < vidx.size(); j++) if (k < 0 && s_trig[vidx[j]]) k = j;
        m_trig_addr = 0; m_wrapped = 0; m_count = 0; m_done = 0; m_done_idx = -1;
        last = -1;
        if (k >= 0) last = (k + leff - 1 < vidx.size()) ? k + leff - 1 : vidx.size() - 1;
        if (c) begin
            if (k < 0) last = vidx.size() - 1;
            for (int j = 0; j <= last; j++) begin
                exp_mem[j % DEPTH]   = s_din[vidx[j]];
                exp_known[j % DEPTH] = 1'b1;
            end
            pre = (k < 0) ? vidx.size() : k + 1;
            m_wrapped = (pre >= DEPTH);
            if (k >= 0) m_trig_addr = k % DEPTH;
        end else if (k >= 0) begin
            for (int j = k; j <= last; j++) begin
                exp_mem[j - k]   = s_din[vidx[j]];
                exp_known[j - k] = 1'b1;
            end
        end
        if (k >= 0) begin
            m_count = last - k + 1;
            m_done  = (m_count == leff);
            if (m_done) m_done_idx = vidx[last];
        end
    endtask

    // Reads every address back to back and compares data and rd_valid timing.
    task automatic readback_check(input string tag);
        int  j;
        logic exp_v;
        for (int i = 0; i < DEPTH + RL; i++) begin
            bus.rd_en   = (i < DEPTH);
            bus.rd_addr = i[AW-1:0];
            tick();
            j = i - RL + 1;
            exp_v = (j >= 0 && j < DEPTH);
            vectors++;
            if (bus.rd_valid !== exp_v) begin
                miss++;
                $display("FAIL %s/rd_valid step %0d: got %b want %b", tag, i, bus.rd_valid, exp_v);
            end
            if (exp_v && exp_known[j]) begin
                vectors++;
                if (bus.rd_data !== exp_mem[j]) begin
                    miss++;
                    $display("FAIL %s/rd_data addr %0d: got %h want %h", tag, j, bus.rd_data, exp_mem[j]);
                end
            end
        end
        bus.rd_en = 1'b0;
        tick();
        vectors++;
        if (bus.rd_valid !== 1'b0 || (exp_known[DEPTH-1] && bus.rd_data !== exp_mem[DEPTH-1])) begin
            miss++;
            $display("FAIL %s/rd_hold: got v=%b d=%h want v=0 d=%h", tag, bus.rd_valid, bus.rd_data, exp_mem[DEPTH-1]);
        end
    endtask

    // Runs one capture and compares status against the model.
    task automatic run_and_check(input string tag, input logic c, input int l, input int n, input bit do_rb);
        drive_stream(c, l[AW:0], n);
        model_capture(c, l, n);
        vectors++;
        if (busy_after_arm !== 1'b1 || done_after_arm !== 1'b0 || count_after_arm !== '0) begin
            miss++;
            $display("FAIL %s/arm_entry: got busy=%b done=%b count=%0d want busy=1 done=0 count=0",
                     tag, busy_after_arm, done_after_arm, count_after_arm);
        end
        vectors++;
        if (bus.done !== m_done || bus.busy !== !m_done) begin
            miss++;
            $display("FAIL %s/done_busy: got done=%b busy=%b want done=%b busy=%b", tag, bus.done, bus.busy, m_done, !m_done);
        end
        vectors++;
        if (bus.count !== m_count[AW:0]) begin
            miss++;
            $display("FAIL %s/count: got %0d want %0d", tag, bus.count, m_count);
        end
        vectors++;
        if (bus.trig_addr !== m_trig_addr[AW-1:0]) begin
            miss++;
            $display("FAIL %s/trig_addr: got %0d want %0d", tag, bus.trig_addr, m_trig_addr);
        end
        vectors++;
        if (bus.wrapped !== m_wrapped) begin
            miss++;
            $display("FAIL %s/wrapped: got %b want %b", tag, bus.wrapped, m_wrapped);
        end
        vectors++;
        if (first_done != m_done_idx) begin
            miss++;
            $display("FAIL %s/done_cycle: got %0d want %0d", tag, first_done, m_done_idx);
        end
        if (do_rb) readback_check(tag);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        vectors++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.trig_addr !== '0 || bus.wrapped !== 1'b0 ||
            bus.count !== '0 || bus.rd_valid !== 1'b0 || bus.rd_data !== '0) begin
            miss++;
            $display("FAIL reset/outputs: got busy=%b done=%b ta=%0d wr=%b cnt=%0d rv=%b rd=%h want all zero",
                     bus.busy, bus.done, bus.trig_addr, bus.wrapped, bus.count, bus.rd_valid, bus.rd_data);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_len_bounds();
        clear_stream();
        for (int i = 1; i <= 24; i++) begin
            s_dv[i] = 1'b1; s_din[i] = 32'h100 + i;
        end
        s_trig[1] = 1'b1;
        run_and_check("len0", 1'b0, 0, 24, 1'b1);
        for (int i = 1; i <= 24; i++) s_din[i] = 32'h200 + i;
        run_and_check("len_over", 1'b0, DEPTH + 5, 24, 1'b1);
    endtask

    task automatic test_oneshot();
        clear_stream();
        for (int i = 1; i <= 9; i++) s_dv[i] = 1'b1;
        s_din[1] = 32'h11; s_din[2] = 32'h12; s_din[3] = 32'h13;
        s_din[4] = 32'hA0; s_trig[4] = 1'b1;
        s_din[5] = 32'hA1; s_din[6] = 32'hA2; s_din[7] = 32'hA3;
        s_din[8] = 32'hB0; s_din[9] = 32'hB1;
        run_and_check("oneshot", 1'b0, 4, 9, 1'b1);
    endtask

    task automatic test_circular();
        clear_stream();
        for (int i = 1; i <= 23; i++) begin
            s_dv[i] = 1'b1; s_din[i] = i - 1;
        end
        s_trig[20] = 1'b1;
        run_and_check("circular", 1'b1, 4, 23, 1'b1);
    endtask

    // Abort mid-capture, then re-arm with arm and trig coinciding and a trig without din_valid.
    task automatic test_arm_restart();
        clear_stream();
        s_dv[1] = 1'b1; s_trig[1] = 1'b1; s_din[1] = 32'hC0;
        s_dv[2] = 1'b1; s_din[2] = 32'hC1;
        run_and_check("abort_first", 1'b0, 8, 3, 1'b0);
        clear_stream();
        s_dv[0] = 1'b1; s_trig[0] = 1'b1; s_din[0] = 32'hEE;
        s_trig[1] = 1'b1; s_din[1] = 32'hEF;
        for (int i = 2; i <= 12; i++) begin
            s_dv[i] = 1'b1; s_din[i] = 32'hD0 + i;
        end
        s_trig[3] = 1'b1;
        run_and_check("rearm", 1'b0, 8, 12, 1'b1);
    endtask

    task automatic test_random();
        for (int r = 0; r < 8; r++) begin
            clear_stream();
            for (int i = 0; i <= 40; i++) begin
                s_dv[i]   = ($urandom % 4) != 0;
                s_trig[i] = ($urandom % 8) == 0;
                s_din[i]  = $urandom;
            end
            run_and_check($sformatf("random%0d", r), 1'($urandom % 2), int'($urandom % 22), 40, 1'b1);
        end
    endtask

    task automatic test_rst_midcapture();
        clear_stream();
        s_dv[1] = 1'b1; s_trig[1] = 1'b1; s_din[1] = 32'h5A5A0001;
        s_dv[2] = 1'b1; s_din[2] = 32'h5A5A0002;
        run_and_check("rst_pre", 1'b0, 8, 3, 1'b0);
        bus.rd_en   = 1'b1;
        bus.rd_addr = '0;
        tick();
        bus.rd_en     = 1'b0;
        bus.din_valid = 1'b1;
        bus.din       = 32'hDEADBEEF;
        #3;
        rst = 1'b1;
        #1;
        vectors++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.trig_addr !== '0 || bus.wrapped !== 1'b0 ||
            bus.count !== '0 || bus.rd_valid !== 1'b0 || bus.rd_data !== '0) begin
            miss++;
            $display("FAIL rst_async/outputs: got busy=%b done=%b ta=%0d wr=%b cnt=%0d rv=%b rd=%h want all zero",
                     bus.busy, bus.done, bus.trig_addr, bus.wrapped, bus.count, bus.rd_valid, bus.rd_data);
        end
        tick();
        vectors++;
        if (bus.rd_valid !== 1'b0) begin
            miss++;
            $display("FAIL rst_async/dropped_read: got rd_valid=%b want 0", bus.rd_valid);
        end
        rst           = 1'b0;
        bus.din_valid = 1'b0;
        tick();
        vectors++;
        if (bus.rd_valid !== 1'b0 || bus.busy !== 1'b0) begin
            miss++;
            $display("FAIL rst_async/after_release: got rd_valid=%b busy=%b want 0 0", bus.rd_valid, bus.busy);
        end
        readback_check("rst_ram");
    endtask

    initial begin
        bus.arm = 1'b0; bus.circ = 1'b0; bus.len = '0; bus.din = '0;
        bus.din_valid = 1'b0; bus.trig = 1'b0; bus.rd_en = 1'b0; bus.rd_addr = '0;
        for (int i = 0; i < DEPTH; i++) begin
            exp_mem[i] = '0; exp_known[i] = 1'b0;
        end
        test_reset();
        test_len_bounds();
        test_oneshot();
        test_circular();
        test_arm_restart();
        test_random();
        test_rst_midcapture();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miss);
        $finish;
    end
endmodule

// File: doc/bram_snap_capture.md
# bram_snap_capture

Parametrised single-clock capture buffer. It writes a fabric data stream into block RAM under control of an arm/trigger state machine, in either one-shot or circular (pre-trigger) mode. A registered random-access read port with configurable latency reads the captured words back. It is the next generation of the plain dual-port BRAM wrapper: depth, width and read latency are generic, and the write side is autonomous instead of being driven address-by-address.

## Interface
- DATA_WIDTH, 32, width of each stored word
- ADDR_WIDTH, 10, word address width; depth = 2^ADDR_WIDTH
- RD_LATENCY, 2, read latency in cycles; legal values are 1 and 2 (2 adds an output register)
- clk  in  1  single clock for all logic and the RAM
- rst  in  1  asynchronous, active-high reset
- arm  in  1  single-cycle pulse: start a new capture, aborting any capture in progress
- circ  in  1  mode, sampled on arm: 0 = one-shot, 1 = circular pre-trigger
- len  in  ADDR_WIDTH+1  post-trigger word count, sampled on arm; 0 or any value > depth means depth
- din  in  DATA_WIDTH  capture data
- din_valid  in  1  din qualifier
- trig  in  1  trigger; honoured only when din_valid=1
- busy  out  1  high in ARMED and CAPTURE
- done  out  1  high in DONE
- trig_addr  out  ADDR_WIDTH  address of the trigger word
- wrapped  out  1  circular mode only: the pre-trigger write pointer wrapped at least once
- count  out  ADDR_WIDTH+1  post-trigger words written so far
- rd_en  in  1  read request
- rd_addr  in  ADDR_WIDTH  read word address
- rd_data  out  DATA_WIDTH  read data
- rd_valid  out  1  pulses RD_LATENCY cycles after rd_en

## Operation
- States: IDLE, ARMED, CAPTURE, DONE.
- IDLE -> ARMED on arm. The cycle after arm:
  - wr_ptr=0, count=0, wrapped=0, trig_addr=0.
  - len and circ are latched.
- ARMED, circ=0: no writes until a cycle with trig & din_valid.
  - That word is written at wr_ptr=0, trig_addr=0, count=1.
  - Next state is CAPTURE, or DONE if len_eff=1.
- ARMED, circ=1: every din_valid cycle writes din at wr_ptr, then wr_ptr increments modulo depth. wrapped is set when wr_ptr goes from depth-1 to 0.
  - A cycle with trig & din_valid writes at wr_ptr and sets trig_addr=wr_ptr and count=1.
  - Next state is CAPTURE, or DONE if len_eff=1.
- CAPTURE: each din_valid writes at wr_ptr, increments wr_ptr modulo depth and increments count. trig is ignored.
  - When count reaches len_eff, the state goes to DONE, with the last write on that same cycle.
- DONE: no writes. done=1 until the next arm. Outputs hold.
- arm in any state, including mid-CAPTURE, restarts from the ARMED entry conditions. Data already in the RAM is not cleared.
- arm and trig in the same cycle: arm wins and the trigger is ignored.
- In circular mode with len_eff=depth, post-trigger data overwrites all pre-trigger data.
- Oldest valid pre-trigger word, circular mode:
  - if wrapped=1: (trig_addr+len_eff) mod depth
  - otherwise: address 0
- Read port is independent of the FSM and legal in any state.
  - Read and write to the same address in the same cycle returns the old data (read-first).
- RAM contents are not affected by rst.

## Timing
- Reset values: state IDLE, busy=0, done=0, trig_addr=0, wrapped=0, count=0, rd_valid=0, rd_data=0.
- arm at cycle t: busy=1 from t+1. The first possible capture write is at t+1.
- The write of a valid word occurs on the edge ending its cycle. count and trig_addr update on that same edge.
- The final write is at cycle t. done=1 and busy=0 from t+1.
- Read: rd_en at cycle t gives rd_data and rd_valid=1 at t+RD_LATENCY.
  - Back-to-back reads are supported, one per cycle.
  - rd_data holds its value between reads.
- Async rst at any time: all outputs return to reset values immediately. Any in-flight read is dropped (no rd_valid).

## Test plan
- One-shot, len=4: arm, then 3 valid words with no trig, then trig on word 0xA0 followed by 0xA1..0xA3.
  - Expected: addresses 0..3 hold A0..A3, trig_addr=0, done one cycle after the A3 write.
  - Expected: readback of 0..3 with RD_LATENCY=2 returns A0..A3, with rd_valid two cycles after each rd_en.
- Circular, ADDR_WIDTH=4, len=4: stream 0..19 continuously, trig on value 19.
  - Expected: trig_addr=3, wrapped=1.
  - Expected: addresses 3..6 hold 19..22, address 7 holds 7 (oldest), done after value 22.
- len=0 and len=depth+5 in one-shot mode: both capture exactly depth words, count=depth at done.
- arm mid-CAPTURE (count=2, len=8): state returns to ARMED, count=0, no done, and a new trigger restarts at address 0.
- arm and trig in the same cycle: trigger ignored, busy=1, count=0. Also: trig with din_valid=0 is ignored.
- rst asserted mid-CAPTURE with a read in flight: outputs reset the same cycle, no rd_valid, and RAM contents are preserved on readback after reset.
